// File: rtl/megaram_mem_bridge.sv
// MegaRAM bus-to-memory bridge: turns cartridge read/write strobes into a single
// memory-controller request per strobe, with wait-state insertion and an access timeout.
module megaram_mem_bridge #(
    parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cart_ena,
    input  logic        ram_ena,
    input  logic [22:0] mem_addr,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  cdin,
    output logic [7:0]  cdout,
    output logic        cdout_oe,
    output logic        wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr_o,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic        is_rd_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cdout_q;
    logic        wait_n_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [22:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        timeout_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            is_rd_q       <= 1'b0;
            cnt_q         <= '0;
            cdout_q       <= '1;
            wait_n_q      <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cart_ena && (!rd_n || !wr_n)) begin
                        cnt_q <= '0;
                        if (!rd_n) begin
                            is_rd_q    <= 1'b1;
                            mem_addr_q <= mem_addr;
                            mem_we_q   <= 1'b0;
                            mem_req_q  <= 1'b1;
                            wait_n_q   <= 1'b0;
                            state_q    <= REQ;
                        end else if (ram_ena) begin
                            is_rd_q     <= 1'b0;
                            mem_addr_q  <= mem_addr;
                            mem_wdata_q <= cdin;
                            mem_we_q    <= 1'b1;
                            mem_req_q   <= 1'b1;
                            wait_n_q    <= 1'b0;
                            state_q     <= REQ;
                        end else begin
                            // Bank-register write: the mapper handles it, memory is untouched.
                            is_rd_q <= 1'b0;
                            state_q <= HOLD;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        wait_n_q  <= 1'b1;
                        if (is_rd_q) cdout_q <= mem_rdata;
                        state_q <= HOLD;
                    end else if (cnt_q == TIMEOUT_CYC - 8'd1) begin
                        // mem_req has now been high for TIMEOUT_CYC cycles.
                        mem_req_q     <= 1'b0;
                        wait_n_q      <= 1'b1;
                        timeout_err_q <= 1'b1;
                        if (is_rd_q) cdout_q <= 8'hFF;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (rd_n && wr_n) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cdout       = cdout_q;
    assign cdout_oe    = (state_q == HOLD) && is_rd_q && !rd_n && cart_ena;
    assign wait_n      = wait_n_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_megaram_mem_bridge.sv
// Directed bench for megaram_mem_bridge: read, RAM write, ROM write, timeout,
// ack/timeout race and mid-access reset, each with hand-computed expectations.
module tb_megaram_mem_bridge;

    logic        clk;
    logic        reset_n;
    logic        cart_ena;
    logic        ram_ena;
    logic [22:0] mem_addr;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  cdin;
    logic [7:0]  cdout;
    logic        cdout_oe;
    logic        wait_n;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr_o;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int req_rises = 0;
    int r0;
    logic req_prev = 1'b0;

    megaram_mem_bridge #(.TIMEOUT_CYC(8'd4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cart_ena   (cart_ena),
        .ram_ena    (ram_ena),
        .mem_addr   (mem_addr),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .cdin       (cdin),
        .cdout      (cdout),
        .cdout_oe   (cdout_oe),
        .wait_n     (wait_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr_o (mem_addr_o),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of mem_req to prove one request per strobe.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && req_prev !== 1'b1) req_rises = req_rises + 1;
        req_prev = mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cdout"},  32'(cdout),       32'hFF);
        chk({tag, "_oe"},     32'(cdout_oe),    32'd0);
        chk({tag, "_wait"},   32'(wait_n),      32'd1);
        chk({tag, "_req"},    32'(mem_req),     32'd0);
        chk({tag, "_we"},     32'(mem_we),      32'd0);
        chk({tag, "_addr"},   32'(mem_addr_o),  32'd0);
        chk({tag, "_wdata"},  32'(mem_wdata),   32'd0);
        chk({tag, "_terr"},   32'(timeout_err), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cart_ena  = 1'b0;
        ram_ena   = 1'b0;
        mem_addr  = '0;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        cdin      = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // Read, memory acks in the 3rd cycle of the request.
        r0 = req_rises;
        cart_ena = 1'b1;
        mem_addr = 23'h420123;
        rd_n     = 1'b0;
        tick();
        chk("rd_req",  32'(mem_req),    32'd1);
        chk("rd_we",   32'(mem_we),     32'd0);
        chk("rd_addr", 32'(mem_addr_o), 32'h420123);
        chk("rd_wait0", 32'(wait_n),    32'd0);
        chk("rd_oe0",  32'(cdout_oe),   32'd0);
        mem_addr = 23'h000001;
        tick();
        chk("rd_wait1", 32'(wait_n),    32'd0);
        chk("rd_addr_stable", 32'(mem_addr_o), 32'h420123);
        tick();
        chk("rd_wait2", 32'(wait_n),    32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        chk("rd_done_req",  32'(mem_req), 32'd0);
        chk("rd_done_wait", 32'(wait_n),  32'd1);
        chk("rd_cdout",     32'(cdout),   32'h5A);
        chk("rd_oe",        32'(cdout_oe), 32'd1);
        tick();
        chk("rd_hold_oe",   32'(cdout_oe), 32'd1);
        chk("rd_one_req",   32'(req_rises - r0), 32'd1);
        rd_n = 1'b1;
        #1;
        chk("rd_oe_off",    32'(cdout_oe), 32'd0);
        tick();
        cart_ena = 1'b0;
        tick();

        // RAM write held low for 10 cycles, ack one cycle after the request.
        r0 = req_rises;
        cart_ena = 1'b1;
        ram_ena  = 1'b1;
        mem_addr = 23'h422000;
        cdin     = 8'hC3;
        wr_n     = 1'b0;
        tick();
        chk("wr_req",   32'(mem_req),    32'd1);
        chk("wr_we",    32'(mem_we),     32'd1);
        chk("wr_wdata", 32'(mem_wdata),  32'hC3);
        chk("wr_addr",  32'(mem_addr_o), 32'h422000);
        chk("wr_wait",  32'(wait_n),     32'd0);
        ram_ena = 1'b0;
        cdin    = 8'h11;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wr_done_req",  32'(mem_req), 32'd0);
        chk("wr_done_wait", 32'(wait_n),  32'd1);
        chk("wr_cdout_keep", 32'(cdout),  32'h5A);
        for (int i = 0; i < 8; i++) tick();
        chk("wr_one_req", 32'(req_rises - r0), 32'd1);
        chk("wr_oe",      32'(cdout_oe), 32'd0);
        wr_n = 1'b1;
        tick();
        cart_ena = 1'b0;
        tick();

        // ROM-mode write: bank register only, no memory request.
        r0 = req_rises;
        cart_ena = 1'b1;
        ram_ena  = 1'b0;
        cdin     = 8'h77;
        wr_n     = 1'b0;
        tick();
        chk("rom_req",  32'(mem_req), 32'd0);
        chk("rom_wait", 32'(wait_n),  32'd1);
        tick();
        tick();
        chk("rom_req2",  32'(mem_req),   32'd0);
        chk("rom_wdata", 32'(mem_wdata), 32'hC3);
        chk("rom_no_req", 32'(req_rises - r0), 32'd0);
        wr_n = 1'b1;
        tick();
        cart_ena = 1'b0;
        tick();

        // Ack coincides with the timeout cycle: data wins, no error.
        cart_ena = 1'b1;
        mem_addr = 23'h400020;
        rd_n     = 1'b0;
        tick();
        chk("race_req", 32'(mem_req), 32'd1);
        tick();
        tick();
        tick();
        chk("race_req4", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 8'h96;
        tick();
        mem_ack = 1'b0;
        chk("race_req_off", 32'(mem_req),     32'd0);
        chk("race_cdout",   32'(cdout),       32'h96);
        chk("race_terr",    32'(timeout_err), 32'd0);
        rd_n = 1'b1;
        tick();
        cart_ena = 1'b0;
        tick();

        // Timeout: no ack, request must drop after 4 cycles.
        cart_ena = 1'b1;
        mem_addr = 23'h400010;
        rd_n     = 1'b0;
        tick();
        chk("to_req1", 32'(mem_req), 32'd1);
        tick();
        tick();
        tick();
        chk("to_req4",  32'(mem_req),     32'd1);
        chk("to_terr0", 32'(timeout_err), 32'd0);
        chk("to_wait4", 32'(wait_n),      32'd0);
        tick();
        chk("to_req_off", 32'(mem_req),     32'd0);
        chk("to_wait",    32'(wait_n),      32'd1);
        chk("to_cdout",   32'(cdout),       32'hFF);
        chk("to_terr",    32'(timeout_err), 32'd1);
        chk("to_oe",      32'(cdout_oe),    32'd1);
        rd_n = 1'b1;
        tick();
        cart_ena = 1'b0;
        tick();
        tick();
        chk("to_terr_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a request, with a late ack straddling release.
        cart_ena = 1'b1;
        mem_addr = 23'h421111;
        rd_n     = 1'b0;
        tick();
        chk("mr_req", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mr");
        rd_n     = 1'b1;
        cart_ena = 1'b0;
        mem_ack  = 1'b1;
        mem_rdata = 8'hEE;
        tick();
        reset_n = 1'b1;
        tick();
        chk("mr_late_req",   32'(mem_req), 32'd0);
        chk("mr_late_cdout", 32'(cdout),   32'hFF);
        chk("mr_late_wait",  32'(wait_n),  32'd1);
        mem_ack = 1'b0;
        tick();

        // Normal read after reset, single-cycle memory latency.
        cart_ena = 1'b1;
        mem_addr = 23'h420123;
        rd_n     = 1'b0;
        tick();
        chk("pr_req",  32'(mem_req),    32'd1);
        chk("pr_addr", 32'(mem_addr_o), 32'h420123);
        mem_ack   = 1'b1;
        mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        chk("pr_cdout", 32'(cdout),       32'h3C);
        chk("pr_wait",  32'(wait_n),      32'd1);
        chk("pr_terr",  32'(timeout_err), 32'd0);
        rd_n = 1'b1;
        tick();
        cart_ena = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/megaram_mem_bridge.md
MEGARAM_MEM_BRIDGE -- requirements
Module: megaram_mem_bridge

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 8'd255, meaning the maximum number of cycles mem_req may wait for mem_ack (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cart_ena, input, 1, cartridge window select from the mapper stage.
REQ-005 SHALL have port ram_ena, input, 1, mapper RAM mode; 1 permits memory writes.
REQ-006 SHALL have port mem_addr, input, 23, translated physical address from the mapper.
REQ-007 SHALL have ports rd_n and wr_n, input, 1 each, bus strobes, active low, already synchronous to clk.
REQ-008 SHALL have port cdin, input, 8, bus write data.
REQ-009 SHALL have port cdout, output, 8, read data returned to the bus.
REQ-010 SHALL have port cdout_oe, output, 1, bus drive enable for cdout.
REQ-011 SHALL have port wait_n, output, 1, bus wait request, active low.
REQ-012 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr_o (output, 23) and mem_wdata (output, 8), forming the memory-controller request.
REQ-013 SHALL have ports mem_ack (input, 1, one-cycle completion pulse) and mem_rdata (input, 8, valid when mem_ack=1).
REQ-014 SHALL have port timeout_err, output, 1, sticky flag set when an access times out.

Function
REQ-015 SHALL implement the states IDLE, REQ and HOLD.
REQ-016 IDLE SHALL detect a start at an edge where cart_ena=1 and (rd_n=0 or wr_n=0).
REQ-017 When rd_n=0 and wr_n=0 are sampled together, the start SHALL be treated as a read.
REQ-018 A read start SHALL, after the same edge, capture mem_addr into mem_addr_o, set mem_we=0, set mem_req=1, set wait_n=0, and enter REQ.
REQ-019 A write start with ram_ena=1 SHALL, after the same edge, capture mem_addr into mem_addr_o and cdin into mem_wdata, set mem_we=1, set mem_req=1, set wait_n=0, and enter REQ.
REQ-020 A write start with ram_ena=0 SHALL issue no memory request, keep wait_n=1, and enter HOLD; this write is a bank-register write owned by the mapper.
REQ-021 In REQ, mem_req, mem_we, mem_addr_o and mem_wdata SHALL stay stable until mem_ack is sampled high.
REQ-022 On mem_ack in REQ, the block SHALL, after that edge, set mem_req=0 and wait_n=1, latch mem_rdata into cdout if the access is a read, and enter HOLD.
REQ-023 A read SHALL therefore take 1 cycle to issue the request plus the memory latency; cdout is valid in the first cycle in which wait_n has returned to 1.
REQ-024 An 8-bit counter SHALL clear on entry to REQ and increment every cycle spent in REQ.
REQ-025 When the counter reaches TIMEOUT_CYC without mem_ack, the block SHALL drop mem_req, set cdout=8'hFF (read), set wait_n=1, set timeout_err=1, and enter HOLD.
REQ-026 mem_ack arriving in the same cycle as the timeout SHALL win: the access completes normally and timeout_err is not set.
REQ-027 mem_ack sampled in IDLE or HOLD SHALL be ignored.
REQ-028 In HOLD, cdout_oe SHALL be 1 only while the access is a read and rd_n=0 and cart_ena=1.
REQ-029 HOLD SHALL return to IDLE at the first edge where rd_n=1 and wr_n=1, so that exactly one memory access occurs per strobe assertion.
REQ-030 Changes of cart_ena or ram_ena while in REQ SHALL NOT affect the in-flight access.
REQ-031 timeout_err SHALL clear only on reset.

Reset
REQ-032 When reset_n=0, asynchronously: state=IDLE, cdout=8'hFF, cdout_oe=0, wait_n=1, mem_req=0, mem_we=0, mem_addr_o=0, mem_wdata=0, counter=0, timeout_err=0.
REQ-033 Reset asserted mid-access SHALL drop mem_req immediately, and no late mem_ack SHALL be acted on after reset is released.

Verification
REQ-034 Read: cart_ena=1, mem_addr=23'h420123, rd_n low, mem_ack after 3 cycles with mem_rdata=8'h5A -> one mem_req with mem_we=0 and mem_addr_o=23'h420123; wait_n low for 3 cycles; cdout=8'h5A with cdout_oe=1 until rd_n rises.
REQ-035 RAM write: ram_ena=1, wr_n low, cdin=8'hC3, mem_addr=23'h422000 -> mem_req with mem_we=1, mem_wdata=8'hC3, mem_addr_o=23'h422000; exactly one request even though wr_n is held low for 10 cycles.
REQ-036 ROM-mode write: ram_ena=0, wr_n low -> mem_req stays 0, wait_n stays 1; state returns to IDLE once wr_n rises.
REQ-037 Timeout: TIMEOUT_CYC=4, read with no mem_ack -> mem_req drops after 4 cycles, cdout=8'hFF, timeout_err=1 until reset.
REQ-038 Race and reset: mem_ack coincident with the timeout -> data latched and timeout_err=0; reset_n pulsed low while in REQ -> all outputs at their reset values immediately, and the next read operates normally.
